// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for mem_port_arbiter: FSM state, access owner and default widths.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 32;
  localparam int unsigned DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIf   = 2'd1,
    OwnDm   = 2'd2
  } owner_e;

endpackage

// File: rtl/arb_priority_pick.sv
// Combinational winner selection: data first, unless the data streak is saturated.
module arb_priority_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic       if_req_i,
  input  logic       dm_req_i,
  input  logic       streak_sat_i,
  output logic [1:0] winner_o
);

  always_comb begin
    winner_o = OwnNone;
    if (if_req_i && (streak_sat_i || !dm_req_i)) begin
      winner_o = OwnIf;
    end else if (dm_req_i) begin
      winner_o = OwnDm;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store as req/ack transactions.
// Define ARB_FAIRNESS_EN to force a fetch grant after MAX_DM_STREAK data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
`ifdef ARB_FAIRNESS_EN
  ,
  parameter int unsigned MAX_DM_STREAK = 4
`endif
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_done_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_done_o,
  output logic              dm_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic [1:0]        winner;
  logic              streak_sat;

  arb_priority_pick u_pick (
    .if_req_i     (if_req_i),
    .dm_req_i     (dm_req_i),
    .streak_sat_i (streak_sat),
    .winner_o     (winner)
  );

`ifdef ARB_FAIRNESS_EN
  localparam int unsigned StreakW = $clog2(MAX_DM_STREAK + 1);

  logic [StreakW-1:0] streak_q, streak_d;

  assign streak_sat = (streak_q == StreakW'(MAX_DM_STREAK));

  // Only data grants that make a waiting fetch wait longer count toward the streak.
  always_comb begin
    streak_d = streak_q;
    if (state_q == StIdle) begin
      if (winner == OwnIf) begin
        streak_d = '0;
      end else if (winner == OwnDm && if_req_i && !streak_sat) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign streak_sat = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (winner != OwnNone) begin
          state_d   = StBusy;
          owner_d   = owner_e'(winner);
          mem_req_d = 1'b1;
          if (winner == OwnDm) begin
            mem_we_d    = dm_we_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
          end
        end
      end
      StBusy: begin
        if (mem_ack_i) begin
          state_d   = StResp;
          mem_req_d = 1'b0;
          if (owner_q == OwnIf) begin
            if_rdata_d = mem_rdata_i;
          end else if (owner_q == OwnDm && !mem_we_q) begin
            dm_rdata_d = mem_rdata_i;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
        owner_d = OwnNone;
      end
      default: begin
        state_d = StIdle;
        owner_d = OwnNone;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      owner_q     <= OwnNone;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_done_o   = (state_q == StResp) && (owner_q == OwnIf);
  assign dm_done_o   = (state_q == StResp) && (owner_q == OwnDm);
  assign if_stall_o  = if_req_i & ~if_done_o;
  assign dm_stall_o  = dm_req_i & ~dm_done_o;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch (read-only) and the memory stage (load/store).
- Sits between the fetch/mem stage logic and the external memory model.
- Sequences each access as a request/ack transaction.
- Produces stall outputs that feed the hazard unit so the pipeline holds while a requester waits.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MAX_DM_STREAK, 4, consecutive data grants allowed while fetch waits; used only with ARB_FAIRNESS_EN.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch read request; held high until if_done.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_rdata  out  DATA_W  fetched instruction; valid while if_done is high, held afterwards.
- if_done  out  1  one-cycle completion pulse for fetch.
- if_stall  out  1  fetch waiting; equals if_req & ~if_done.
- dm_req  in  1  data request; held high until dm_done.
- dm_we  in  1  1 = store, 0 = load; stable with dm_req.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; valid while dm_done is high, held afterwards.
- dm_done  out  1  one-cycle completion pulse for data.
- dm_stall  out  1  data waiting; equals dm_req & ~dm_done.
- mem_req  out  1  memory request; held high until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack is high.
- mem_ack  in  1  one-cycle memory completion pulse; latency of 1 or more cycles after mem_req.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, owner=NONE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_done=0, dm_done=0, if_rdata=0, dm_rdata=0.
  - streak counter=0.
  - Reset mid-transaction abandons the access; a late mem_ack after reset is ignored.
- States:
  - IDLE → BUSY when any request is high.
  - BUSY → RESP on mem_ack.
  - RESP → IDLE unconditionally.
- IDLE arbitration:
  - dm_req has priority over if_req.
  - On grant, mem_req/mem_we/mem_addr/mem_wdata are registered from the winner at the same edge.
  - mem_we=0 for fetch grants.
- BUSY:
  - mem_* outputs are held constant.
  - On mem_ack, mem_req drops at the same edge.
  - For a read, mem_rdata is captured into the winner's rdata register.
- RESP:
  - Winner's done=1 for exactly this cycle.
  - Stores do not modify dm_rdata.
  - No arbitration occurs in RESP.
- Latency: minimum 3 cycles from request to done (IDLE grant edge, ack edge, RESP cycle), assuming an ack 1 cycle after mem_req.
- Simultaneous requests: data served first; fetch stays pending with if_stall=1, then is served from the next IDLE.
- mem_ack while IDLE or RESP is ignored; no state change.
- Requests dropped before done: protocol violation, behaviour unspecified.
- Back-to-back: a requester keeping req high during its RESP cycle is treated as a new request in the following IDLE.

Optional Feature:
- Macro ARB_FAIRNESS_EN.
- Enabled:
  - Streak counter increments on each data grant made while if_req is high.
  - Counter clears on any fetch grant.
  - When the counter equals MAX_DM_STREAK, the next IDLE grant goes to fetch even if dm_req is high.
- Disabled: strict data priority; no counter logic is synthesised.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2);
  - owner encoding (NONE, IF, DM);
  - default widths ADDR_W/DATA_W=32.
- One sub-module is natural: arb_priority_pick. It is combinational: inputs if_req, dm_req and the streak-saturated flag; output is the winner.
- FSM and registers stay in the top module.

Test Plan:
1. Single fetch, if_addr=0x0040_0000, mem_ack 1 cycle after mem_req with mem_rdata=0x2008_0005 → if_rdata=0x2008_0005 and one-cycle if_done in the 3rd cycle; mem_we=0.
2. Simultaneous if_req and dm_req (load from 0x1001_0000, rdata 0xDEAD_BEEF) → data served first; dm_done, then if_done ≥3 cycles later; if_stall=1 throughout.
3. Store: dm_we=1, addr 0x1001_0004, wdata 0x0000_00AA → mem_we=1 with matching addr/wdata held until ack; dm_rdata unchanged; dm_done pulses once.
4. Memory with 5-cycle ack latency → mem_* stable for 5 cycles; done exactly one cycle; no second mem_req until after RESP.
5. reset_n low while in BUSY → all outputs 0 immediately; a subsequent stray mem_ack produces no done pulse.
6. With ARB_FAIRNESS_EN and MAX_DM_STREAK=4: dm_req held continuously with if_req pending → fetch granted after exactly 4 data transactions; without the macro, fetch is never granted while dm_req stays high.
